// File: rtl/pipe_ctrl.sv
// Pipeline control carrier and hazard unit: carries decoded control ID->EX->MEM->WB, one cycle per boundary.
// Holds PC and IF/ID for one cycle on a load-use hazard and flushes two slots on a taken branch/jump.
module pipe_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       id_RegDst,
  input  logic       id_ALUSrc,
  input  logic       id_MemtoReg,
  input  logic       id_RegWrite,
  input  logic       id_MemRead,
  input  logic       id_MemWrite,
  input  logic       id_Branch,
  input  logic       id_Jump,
  input  logic [1:0] id_ALUOp,
  input  logic       ex_zero,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic [1:0] pc_src,
  output logic       ex_ALUSrc,
  output logic [1:0] ex_ALUOp,
  output logic [4:0] ex_wreg,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_MemRead,
  output logic       mem_MemWrite,
  output logic [4:0] mem_wreg,
  output logic       wb_RegWrite,
  output logic       wb_MemtoReg,
  output logic [4:0] wb_wreg
);

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
  } idex_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] wreg;
  } exmem_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] wreg;
  } memwb_t;

  idex_t  idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;
  logic   stall, taken;

  // MEM result is newer than WB, so it wins; $0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input exmem_t m, input memwb_t w);
    if (m.reg_write && (m.wreg != 5'd0) && (m.wreg == src))
      return 2'b10;
    else if (w.reg_write && (w.wreg != 5'd0) && (w.wreg == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    stall = id_valid & idex_q.mem_read & (idex_q.wreg != 5'd0) &
            ((idex_q.wreg == id_rs) | (idex_q.wreg == id_rt));
    taken = idex_q.jump | (idex_q.branch & ex_zero);

    pc_src = 2'b00;
    if (idex_q.jump)
      pc_src = 2'b10;
    else if (idex_q.branch & ex_zero)
      pc_src = 2'b01;

    pc_write   = ~stall | taken;
    ifid_write = ~stall | taken;
    ifid_flush = taken;

    idex_d = '0;
    if (id_valid && !stall && !taken) begin
      idex_d.alu_src    = id_ALUSrc;
      idex_d.alu_op     = id_ALUOp;
      idex_d.reg_write  = id_RegWrite;
      // Non-writing instructions carry no destination, masking decoder don't-cares.
      idex_d.mem_to_reg = id_RegWrite & id_MemtoReg;
      idex_d.mem_read   = id_MemRead;
      idex_d.mem_write  = id_MemWrite;
      idex_d.branch     = id_Branch;
      idex_d.jump       = id_Jump;
      idex_d.rs         = id_rs;
      idex_d.rt         = id_rt;
      idex_d.wreg       = id_RegWrite ? (id_RegDst ? id_rd : id_rt) : 5'd0;
    end

    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.mem_read   = idex_q.mem_read;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.wreg       = idex_q.wreg;

    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.wreg       = exmem_q.wreg;

    fwd_a = fwd_sel(idex_q.rs, exmem_q, memwb_q);
    fwd_b = fwd_sel(idex_q.rt, exmem_q, memwb_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_ALUSrc    = idex_q.alu_src;
  assign ex_ALUOp     = idex_q.alu_op;
  assign ex_wreg      = idex_q.wreg;
  assign mem_MemRead  = exmem_q.mem_read;
  assign mem_MemWrite = exmem_q.mem_write;
  assign mem_wreg     = exmem_q.wreg;
  assign wb_RegWrite  = memwb_q.reg_write;
  assign wb_MemtoReg  = memwb_q.mem_to_reg;
  assign wb_wreg      = memwb_q.wreg;

endmodule
